// File: rtl/spi_receiver_if.sv
// Pin and handshake bundle for spi_receiver: SPI wires from the controller
// plus the parallel byte output with its VALID/ACK handshake and status flags.
interface spi_receiver_if;
   logic       SCK;
   logic       SDI;
   logic       CSX;
   logic [7:0] OUT;
   logic       VALID;
   logic       ACK;
   logic       BUSY;
   logic       OVERRUN;
   logic       FRAME_ERR;

   modport slave (
      input  SCK, SDI, CSX, ACK,
      output OUT, VALID, BUSY, OVERRUN, FRAME_ERR
   );

   modport master (
      output SCK, SDI, CSX, ACK,
      input  OUT, VALID, BUSY, OVERRUN, FRAME_ERR
   );
endinterface

// File: rtl/spi_receiver.sv
// SPI mode-0 peripheral receiver: oversamples SCK/SDI/CSX on CLK_100MHz and
// delivers completed bytes through a single-entry VALID/ACK holding register.
module spi_receiver #(
   parameter int SYNC_STAGES = 2,
   parameter bit MSB_FIRST   = 1'b1
) (
   input  logic          CLK_100MHz,
   input  logic          RST_N,
   spi_receiver_if.slave bus
);

   typedef enum logic {IDLE, RECEIVE} state_t;

   localparam int LAST = SYNC_STAGES - 1;

   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] sdi_sync;
   logic [SYNC_STAGES-1:0] csx_sync;
   logic                   sck_prev;
   logic                   csx_prev;

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] out_q, out_d;
   logic       valid_q, valid_d;
   logic       ovr_q, ovr_d;
   logic       ferr_q, ferr_d;

   logic       sck_rise;
   logic       csx_fall;
   logic       csx_rise;
   logic       sdi_s;
   logic [7:0] shifted;

   // CSX flops reset to 0 (asserted) so a CSX held low through reset never looks like a frame start.
   always_ff @(posedge CLK_100MHz) begin
      if (!RST_N) begin
         sck_sync <= '0;
         sdi_sync <= '0;
         csx_sync <= '0;
         sck_prev <= 1'b0;
         csx_prev <= 1'b0;
      end else begin
         sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.SCK};
         sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], bus.SDI};
         csx_sync <= {csx_sync[SYNC_STAGES-2:0], bus.CSX};
         sck_prev <= sck_sync[LAST];
         csx_prev <= csx_sync[LAST];
      end
   end

   assign sck_rise = sck_sync[LAST] & ~sck_prev;
   assign csx_fall = ~csx_sync[LAST] & csx_prev;
   assign csx_rise = csx_sync[LAST] & ~csx_prev;
   assign sdi_s    = sdi_sync[LAST];
   assign shifted  = MSB_FIRST ? {shift_q[6:0], sdi_s} : {sdi_s, shift_q[7:1]};

   always_ff @(posedge CLK_100MHz) begin
      if (!RST_N) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         shift_q <= 8'h00;
         out_q   <= 8'h00;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
      end
   end

   // ACK is applied first so a byte completing in the same cycle re-asserts VALID without flagging overrun.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      out_d   = out_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      ferr_d  = ferr_q;

      if (bus.ACK && valid_q) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (csx_fall) begin
               state_d = RECEIVE;
               cnt_d   = 3'd0;
               shift_d = 8'h00;
               ferr_d  = 1'b0;
            end
         end
         RECEIVE: begin
            if (csx_rise) begin
               state_d = IDLE;
               cnt_d   = 3'd0;
               shift_d = 8'h00;
               if (cnt_q != 3'd0) begin
                  ferr_d = 1'b1;
               end
            end else if (sck_rise) begin
               cnt_d   = cnt_q + 3'd1;
               shift_d = shifted;
               if (cnt_q == 3'd7) begin
                  out_d   = shifted;
                  valid_d = 1'b1;
                  if (valid_q && !bus.ACK) begin
                     ovr_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.OUT       = out_q;
   assign bus.VALID     = valid_q;
   assign bus.BUSY      = (state_q == RECEIVE);
   assign bus.OVERRUN   = ovr_q;
   assign bus.FRAME_ERR = ferr_q;

endmodule

// File: doc/spi_receiver.md
Name: spi_receiver

Overview:
- SPI peripheral-side receiver: deserialises bytes from an external SPI controller (mode 0, MSB first, CSX active low) into parallel 8-bit words for fabric logic.
- Counterpart to the team's SPI transmitter; used for loopback self-test and for accepting bytes from external controllers.
- Oversamples SCK/SDI/CSX on the 100 MHz system clock.
- Single-entry output holding register with VALID/ACK handshake and sticky error flags.

Parameters:
- SYNC_STAGES, 2, synchroniser depth applied identically to SCK, SDI and CSX (minimum 2).
- MSB_FIRST, 1, 1 = first received bit lands in OUT[7]; 0 = first received bit lands in OUT[0].

Ports:
- CLK_100MHz  input  1  system clock.
- RST_N  input  1  synchronous, active-low reset.
- SCK  input  1  SPI clock from controller (asynchronous).
- SDI  input  1  SPI data from controller (asynchronous).
- CSX  input  1  SPI chip select, active low (asynchronous).
- OUT  output  8  last completed byte.
- VALID  output  1  OUT holds an unconsumed byte (level).
- ACK  input  1  consumer pop; meaningful only while VALID = 1.
- BUSY  output  1  frame in progress (state RECEIVE).
- OVERRUN  output  1  sticky; a byte completed while the previous byte was unconsumed.
- FRAME_ERR  output  1  sticky; CSX deasserted with a partial byte.

Behaviour:
- Clock and reset:
  - One clock: CLK_100MHz.
  - Reset is synchronous and active-low: RST_N = 0 sampled at the CLK_100MHz rising edge.
- Reset values:
  - OUT = 0, VALID = 0, BUSY = 0, OVERRUN = 0, FRAME_ERR = 0.
  - state = IDLE, bit counter = 0, shift register = 0.
  - SCK synchroniser and previous-value flops = 0.
  - CSX synchroniser and previous-value flops = 0 (active). A CSX held low through reset release therefore produces no falling edge; the block waits for CSX to go high and then low again.
- Synchronisation and edge detection:
  - All three inputs pass through SYNC_STAGES flops.
  - Edges are detected from the last stage versus a one-cycle-delayed copy.
  - SDI is taken from its own last stage, sampled in the same cycle the SCK rise is detected.
- State machine:
  - IDLE: on CSX falling edge, go to RECEIVE and clear the bit counter and shift register. SCK edges in IDLE, or in the same cycle as the CSX fall, are ignored.
  - RECEIVE, on SCK rising edge: shift in the SDI sample and increment the bit counter (3 bits, modulo 8).
  - RECEIVE, completing bit 8:
    - Load OUT from the shifted value; the counter wraps to 0 and reception continues. Multiple bytes per frame are supported.
    - VALID = 1 from the next cycle.
  - RECEIVE, on CSX rising edge: go to IDLE.
    - If bit counter != 0, discard the partial byte and set FRAME_ERR.
    - An SCK rise in the same cycle is ignored; CSX wins.
- Latency:
  - Let k be the first clock edge that samples SCK = 1 into stage 1 for the 8th bit.
  - OUT/VALID update at edge k + SYNC_STAGES.
- Handshake:
  - ACK while VALID = 1: VALID clears next cycle.
  - ACK while VALID = 0: ignored.
  - Byte completion in the same cycle as ACK: OUT takes the new byte, VALID stays 1, no overrun.
- Overrun:
  - Byte completion while VALID = 1 and ACK = 0: OUT is overwritten with the newest byte, VALID stays 1, OVERRUN is set.
  - OVERRUN clears only on reset or on ACK.
- FRAME_ERR: clears on reset or on the next CSX falling edge (frame start).
- Bit ordering:
  - MSB_FIRST = 1: shift left, inserting SDI at bit 0.
  - MSB_FIRST = 0: shift right, inserting SDI at bit 7.
- Reset mid-frame: all state clears; the remainder of the frame is ignored until a fresh CSX high-then-low sequence.

Test Plan:
- Single byte: CSX low, 8 SCK periods of 20 clocks carrying 0xA5 MSB first, CSX high -> VALID = 1 and OUT = 0xA5 exactly SYNC_STAGES clocks after the 8th SCK rise is sampled; FRAME_ERR = 0; BUSY falls after CSX rise.
- Multi-byte frame with ACK: bytes 0x3C, 0xC3 in one frame, ACK pulsed after each -> OUT = 0x3C then 0xC3, VALID pulses twice, OVERRUN = 0.
- Overrun: send 0x11 then 0x22 without ACK -> OUT = 0x22, VALID = 1, OVERRUN = 1; a single ACK -> VALID = 0, OVERRUN = 0.
- Completion coincident with ACK: ACK asserted in the exact cycle the 2nd byte 0x7E completes -> VALID stays 1, OUT = 0x7E, OVERRUN = 0.
- Partial frame: CSX high after 5 bits -> VALID unchanged, FRAME_ERR = 1; next frame with 0x0F -> FRAME_ERR clears at the CSX fall, OUT = 0x0F.
- Reset mid-frame plus LSB-first: RST_N low after 3 bits of 0xFF with CSX held low -> all outputs 0, remaining SCK edges ignored until CSX cycles high then low; with MSB_FIRST = 0, bit stream 1,0,0,0,0,0,0,0 -> OUT = 0x01.
